// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, pattern encodings and colour-bar table for the VGA
// display path.
package vga_timing_pkg;

  // 640x480 @ 60 Hz with a 25 MHz pixel clock
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_COLOR_W    = 4;
  localparam bit DEF_SYNC_POL   = 1'b0;
  localparam int DEF_CHECK_LOG2 = 5;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  localparam int BAR_COUNT = 8;

  // {R,G,B} on-flags, index 0 is the leftmost bar:
  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [BAR_COUNT-1:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return BAR_RGB[idx];
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// VGA pattern bus: pattern-select inputs toward the generator, pixel/sync
// stream and coordinates back out to the pins and overlay logic.
interface vga_pattern_gen_if #(
  parameter int COLOR_W = 4,
  parameter int X_W     = 10,
  parameter int Y_W     = 10
);
  logic [1:0]           i_mode;
  logic [3*COLOR_W-1:0] i_solid_rgb;
  logic [COLOR_W-1:0]   o_red;
  logic [COLOR_W-1:0]   o_green;
  logic [COLOR_W-1:0]   o_blue;
  logic                 o_hsync;
  logic                 o_vsync;
  logic                 o_video;
  logic [X_W-1:0]       o_x;
  logic [Y_W-1:0]       o_y;
  logic                 o_frame_start;

  modport master (
    output i_mode, i_solid_rgb,
    input  o_red, o_green, o_blue, o_hsync, o_vsync, o_video,
           o_x, o_y, o_frame_start
  );

  modport slave (
    input  i_mode, i_solid_rgb,
    output o_red, o_green, o_blue, o_hsync, o_vsync, o_video,
           o_x, o_y, o_frame_start
  );
endinterface

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters with unregistered sync, active-area and
// end-of-frame decode.
module vga_sync_counter #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int X_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int Y_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic           w_clk25m,
  input  logic           w_rst_btn_db,
  output logic [X_W-1:0] o_h_cnt,
  output logic [Y_W-1:0] o_v_cnt,
  output logic           o_hs,
  output logic           o_vs,
  output logic           o_active,
  output logic           o_frame_end
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [X_W-1:0] h_cnt_q, h_cnt_d;
  logic [Y_W-1:0] v_cnt_q, v_cnt_d;
  logic           h_last, v_last;

  assign h_last = (h_cnt_q == X_W'(H_TOTAL - 1));
  assign v_last = (v_cnt_q == Y_W'(V_TOTAL - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    h_cnt_d = h_cnt_q + X_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + Y_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge w_clk25m or negedge w_rst_btn_db) begin
    if (!w_rst_btn_db) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign o_h_cnt     = h_cnt_q;
  assign o_v_cnt     = v_cnt_q;
  assign o_hs        = (h_cnt_q >= X_W'(H_ACTIVE + H_FP)) &&
                       (h_cnt_q <  X_W'(H_ACTIVE + H_FP + H_SYNC));
  assign o_vs        = (v_cnt_q >= Y_W'(V_ACTIVE + V_FP)) &&
                       (v_cnt_q <  Y_W'(V_ACTIVE + V_FP + V_SYNC));
  assign o_active    = (h_cnt_q < X_W'(H_ACTIVE)) && (v_cnt_q < Y_W'(V_ACTIVE));
  assign o_frame_end = h_last && v_last;

endmodule

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator: frame-latched pattern
// select, four patterns, one registered output stage aligned with o_x/o_y.
module vga_pattern_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter bit SYNC_POL   = DEF_SYNC_POL,
  parameter int CHECK_LOG2 = DEF_CHECK_LOG2
) (
  input  logic             w_clk25m,
  input  logic             w_rst_btn_db,
  vga_pattern_gen_if.slave vga
);
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_W        = $clog2(H_TOTAL);
  localparam int Y_W        = $clog2(V_TOTAL);
  localparam int RGB_W      = 3 * COLOR_W;
  localparam int BAR_W      = X_W + 3;
  localparam int GRAD_SHIFT = $clog2(H_ACTIVE) - COLOR_W;
  localparam logic [X_W-1:0] GRAD_MAX = X_W'((1 << COLOR_W) - 1);

  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic           hs, vs, active, frame_end;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_sync (
    .w_clk25m     (w_clk25m),
    .w_rst_btn_db (w_rst_btn_db),
    .o_h_cnt      (h_cnt),
    .o_v_cnt      (v_cnt),
    .o_hs         (hs),
    .o_vs         (vs),
    .o_active     (active),
    .o_frame_end  (frame_end)
  );

  // Shadow copies of the pattern select, reloaded only on the last pixel of a
  // frame so a change shows up exactly from pixel (0,0) of the next one.
  mode_e            mode_q, mode_d;
  logic [RGB_W-1:0] solid_q, solid_d;

  always_comb begin
    mode_d  = mode_q;
    solid_d = solid_q;
    if (frame_end) begin
      mode_d  = mode_e'(vga.i_mode);
      solid_d = vga.i_solid_rgb;
    end
  end

  // Bar index = h_cnt*8/H_ACTIVE, found by comparing h_cnt*8 against k*H_ACTIVE
  logic [2:0] bar_idx;
  logic [2:0] bar_on;

  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < BAR_COUNT; k++) begin
      if ({h_cnt, 3'b000} >= BAR_W'(k * H_ACTIVE)) bar_idx = 3'(k);
    end
  end

  assign bar_on = bar_rgb(bar_idx);

  logic [X_W-1:0]     grad_raw;
  logic [COLOR_W-1:0] grad_lvl;
  logic               check_on;

  assign grad_raw = h_cnt >> GRAD_SHIFT;
  assign grad_lvl = (grad_raw > GRAD_MAX) ? '1 : grad_raw[COLOR_W-1:0];
  assign check_on = h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2];

  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_q, video_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             frame_start_q, frame_start_d;

  always_comb begin
    rgb_d = '0;
    if (active) begin
      case (mode_q)
        MODE_SOLID: rgb_d = solid_q;
        MODE_BARS:  rgb_d = {{COLOR_W{bar_on[2]}}, {COLOR_W{bar_on[1]}},
                             {COLOR_W{bar_on[0]}}};
        MODE_CHECK: rgb_d = {RGB_W{check_on}};
        MODE_GRAD:  rgb_d = {grad_lvl, grad_lvl, grad_lvl};
        default:    rgb_d = '0;
      endcase
    end
    hsync_d       = hs ? SYNC_POL : ~SYNC_POL;
    vsync_d       = vs ? SYNC_POL : ~SYNC_POL;
    video_d       = active;
    x_d           = h_cnt;
    y_d           = v_cnt;
    frame_start_d = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge w_clk25m or negedge w_rst_btn_db) begin
    if (!w_rst_btn_db) begin
      mode_q        <= MODE_SOLID;
      solid_q       <= '0;
      rgb_q         <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      solid_q       <= solid_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_q       <= video_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.o_red         = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign vga.o_green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga.o_blue        = rgb_q[COLOR_W-1:0];
  assign vga.o_hsync       = hsync_q;
  assign vga.o_vsync       = vsync_q;
  assign vga.o_video       = video_q;
  assign vga.o_x           = x_q;
  assign vga.o_y           = y_q;
  assign vga.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised self-checking bench for vga_pattern_gen on a reduced raster,
// compared pixel by pixel against a frame-level reference model.
module tb_vga_pattern_gen;
  localparam int HA = 80, HFP = 6, HSW = 10, HBP = 4;
  localparam int VA = 40, VFP = 3, VSW = 2,  VBP = 5;
  localparam int CW = 4;
  localparam bit SP = 1'b0;
  localparam int CL = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  localparam int GS = $clog2(HA) - CW;
  localparam int NF = 7;

  logic w_clk25m = 1'b0;
  logic w_rst_btn_db = 1'b0;

  vga_pattern_gen_if #(.COLOR_W(CW), .X_W(XW), .Y_W(YW)) vga ();

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .COLOR_W(CW), .SYNC_POL(SP), .CHECK_LOG2(CL)
  ) dut (
    .w_clk25m     (w_clk25m),
    .w_rst_btn_db (w_rst_btn_db),
    .vga          (vga)
  );

  always #20 w_clk25m = ~w_clk25m;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: cycles since reset release, pattern in force for
  // the current frame, and per-line / per-frame statistics.
  int          k;
  logic [1:0]  cur_mode;
  logic [11:0] cur_rgb;
  int          hs_cnt, vs_cnt, fs_cnt, last_fs;
  logic [1:0]  plan_mode [NF+1];
  logic [11:0] plan_rgb  [NF+1];

  function automatic logic [2:0] bar_colour(input int bar);
    case (bar)
      0: return 3'b111;  // white
      1: return 3'b110;  // yellow
      2: return 3'b011;  // cyan
      3: return 3'b010;  // green
      4: return 3'b101;  // magenta
      5: return 3'b100;  // red
      6: return 3'b001;  // blue
      default: return 3'b000;  // black
    endcase
  endfunction

  function automatic logic [28:0] expect_pix(input int x, input int y,
                                             input logic [1:0] m,
                                             input logic [11:0] rgb);
    bit act, hs, vs, fs;
    logic [3:0] r, g, b;
    logic [2:0] on;
    int lvl;
    act = (x < HA) && (y < VA);
    hs  = (x >= HA + HFP && x < HA + HFP + HSW) ? SP : !SP;
    vs  = (y >= VA + VFP && y < VA + VFP + VSW) ? SP : !SP;
    fs  = (x == 0) && (y == 0);
    r = 4'h0; g = 4'h0; b = 4'h0;
    if (act) begin
      case (m)
        2'd0: begin r = rgb[11:8]; g = rgb[7:4]; b = rgb[3:0]; end
        2'd1: begin
          on = bar_colour(x * 8 / HA);
          r = on[2] ? 4'hF : 4'h0;
          g = on[1] ? 4'hF : 4'h0;
          b = on[0] ? 4'hF : 4'h0;
        end
        2'd2: begin
          if ((((x >> CL) ^ (y >> CL)) & 1) == 1) begin
            r = 4'hF; g = 4'hF; b = 4'hF;
          end
        end
        default: begin
          lvl = x / (1 << GS);
          if (lvl > 15) lvl = 15;
          r = 4'(lvl); g = 4'(lvl); b = 4'(lvl);
        end
      endcase
    end
    return {act, hs, vs, fs, 7'(x), 6'(y), r, g, b};
  endfunction

  function automatic logic [28:0] observed();
    return {vga.o_video, vga.o_hsync, vga.o_vsync, vga.o_frame_start,
            vga.o_x, vga.o_y, vga.o_red, vga.o_green, vga.o_blue};
  endfunction

  task automatic restart_model();
    k = 0; cur_mode = 2'd0; cur_rgb = 12'h000;
    hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; last_fs = -1;
  endtask

  // One pixel clock: let the DUT take an edge, then compare on the falling edge.
  task automatic step();
    int x, y;
    logic [11:0] rgb_o;
    @(posedge w_clk25m);
    @(negedge w_clk25m);
    x = k % HT;
    y = (k / HT) % VT;
    rgb_o = {vga.o_red, vga.o_green, vga.o_blue};
    check("pixel", 64'(observed()), 64'(expect_pix(x, y, cur_mode, cur_rgb)));

    if (cur_mode == 2'd1 && y == 0) begin
      if (x == 0)      check("bar_white",  64'(rgb_o), 64'h FFF);
      if (x == HA / 8) check("bar_yellow", 64'(rgb_o), 64'h FF0);
      if (x == HA - 1) check("bar_black",  64'(rgb_o), 64'h 000);
      if (x == HA)     check("bar_blank",  64'({vga.o_video, rgb_o}), 64'h0);
    end
    if (cur_mode == 2'd2) begin
      if (y == 0 && x == 7) check("check_7_0",  64'(rgb_o), 64'h000);
      if (y == 0 && x == 8) check("check_8_0",  64'(rgb_o), 64'hFFF);
      if (y == 8 && x == 8) check("check_8_8",  64'(rgb_o), 64'h000);
    end
    if (cur_mode == 2'd3 && y == 1) begin
      if (x == 0)      check("grad_0",   64'(rgb_o), 64'h000);
      if (x == 8)      check("grad_8",   64'(rgb_o), 64'h111);
      if (x == HA - 1) check("grad_max", 64'(rgb_o), 64'h999);
    end

    if (vga.o_hsync == SP) hs_cnt++;
    if (x == HT - 1) begin
      check("hsync_width", 64'(hs_cnt), 64'(HSW));
      hs_cnt = 0;
    end
    if (vga.o_vsync == SP) vs_cnt++;
    if (vga.o_frame_start) begin
      fs_cnt++;
      if (last_fs >= 0) check("frame_period", 64'(k - last_fs), 64'(FRAME));
      last_fs = k;
    end
    if (k % FRAME == FRAME - 1) begin
      check("vsync_clocks", 64'(vs_cnt), 64'(VSW * HT));
      check("frame_pulses", 64'(fs_cnt), 64'd1);
      vs_cnt = 0; fs_cnt = 0;
      // inputs present at this edge become next frame's pattern
      cur_mode = vga.i_mode;
      cur_rgb  = vga.i_solid_rgb;
    end
    k++;
  endtask

  initial begin
    vga.i_mode      = 2'd0;
    vga.i_solid_rgb = 12'h000;
    restart_model();

    repeat (3) @(negedge w_clk25m);
    check("reset_state", 64'(observed()),
          64'({1'b0, !SP, !SP, 1'b0, 7'd0, 6'd0, 12'h000}));

    plan_mode[1] = 2'd0; plan_rgb[1] = 12'h00F;
    plan_mode[2] = 2'd1; plan_rgb[2] = 12'($urandom);
    plan_mode[3] = 2'd2; plan_rgb[3] = 12'($urandom);
    plan_mode[4] = 2'd3; plan_rgb[4] = 12'($urandom);
    for (int f = 5; f <= NF; f++) begin
      plan_mode[f] = 2'($urandom_range(0, 3));
      plan_rgb[f]  = 12'($urandom);
    end

    vga.i_mode      = plan_mode[1];
    vga.i_solid_rgb = plan_rgb[1];
    w_rst_btn_db    = 1'b1;

    // Frame 0 is black from the reset shadow; inputs wander in the first half
    // of each frame and settle on the next frame's plan mid-frame.
    for (int f = 0; f < NF; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        step();
        if (c < FRAME / 2 && $urandom_range(0, 199) == 0) begin
          vga.i_mode      = 2'($urandom_range(0, 3));
          vga.i_solid_rgb = 12'($urandom);
        end else if (c == FRAME / 2) begin
          vga.i_mode      = plan_mode[f + 1];
          vga.i_solid_rgb = plan_rgb[f + 1];
        end
      end
    end

    // Run to pixel (30,20), then pull reset between clock edges.
    for (int c = 0; c < FRAME && (k % FRAME) != 20 * HT + 31; c++) step();
    #5 w_rst_btn_db = 1'b0;
    #1 check("async_reset", 64'(observed()),
             64'({1'b0, !SP, !SP, 1'b0, 7'd0, 6'd0, 12'h000}));
    vga.i_mode      = 2'd1;
    vga.i_solid_rgb = 12'hFFF;
    repeat (3) @(negedge w_clk25m);
    check("reset_held", 64'(observed()),
          64'({1'b0, !SP, !SP, 1'b0, 7'd0, 6'd0, 12'h000}));

    restart_model();
    w_rst_btn_db = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised VGA timing and test-pattern generator; the next generation of the fixed blue-screen display path.
- Generalises resolution, porch and sync timing, sync polarity and colour depth.
- Adds four runtime-selectable patterns, switched glitch-free at frame boundaries, plus a frame-start strobe.
- Sits between the 25 MHz clock/reset conditioning and the board VGA pins; also exports pixel coordinates for downstream overlay logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- COLOR_W, 4, bits per colour channel
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)
- CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels

Ports:
- w_clk25m  in  1  pixel clock, 25 MHz
- w_rst_btn_db  in  1  reset, asynchronous, active-low
- i_mode  in  2  pattern select; 0 solid, 1 colour bars, 2 checkerboard, 3 grey gradient
- i_solid_rgb  in  3*COLOR_W  solid colour {R,G,B}, used in mode 0
- o_red  out  COLOR_W  red channel
- o_green  out  COLOR_W  green channel
- o_blue  out  COLOR_W  blue channel
- o_hsync  out  1  horizontal sync
- o_vsync  out  1  vertical sync
- o_video  out  1  high in active area
- o_x  out  clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)  horizontal pixel counter
- o_y  out  clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)  vertical line counter
- o_frame_start  out  1  one-cycle pulse coincident with pixel (0,0)

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters (800 at defaults); V_TOTAL = sum of the V_* parameters (525 at defaults).
- Counters h_cnt and v_cnt:
  - h_cnt increments every clock and wraps H_TOTAL-1 -> 0.
  - v_cnt increments when h_cnt wraps and wraps V_TOTAL-1 -> 0.
- Active area: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Sync assertion:
  - hsync asserted (level SYNC_POL) for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted on the same rule applied to v_cnt with the V_* parameters.
- Latency: every output is registered one cycle after its counter state; all outputs are mutually aligned.
  - o_x and o_y equal the counter values of the pixel currently being presented.
- Mode latch:
  - i_mode and i_solid_rgb are sampled into shadow registers only on the cycle where h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1.
  - The new pattern takes effect exactly from pixel (0,0) of the next frame.
  - Mid-frame input changes have no visible effect until that point.
- Patterns (active area only):
  - Mode 0: RGB = latched i_solid_rgb.
  - Mode 1: 8 vertical bars, bar index = h_cnt*8/H_ACTIVE (implemented as a compare chain, no divider). Bars run, left to right, white, yellow, cyan, green, magenta, red, blue, black. A channel that is "on" is all ones.
  - Mode 2: checkerboard; white when h_cnt[CHECK_LOG2] XOR v_cnt[CHECK_LOG2] = 1, else black.
  - Mode 3: R = G = B = h_cnt >> (clog2(H_ACTIVE)-COLOR_W), saturated to all ones.
- Blanking: outside the active area, RGB = 0 regardless of mode.
- o_frame_start: high for exactly one cycle per frame, on the cycle o_x = 0 and o_y = 0.
- Reset (w_rst_btn_db low, asynchronous):
  - Counters = 0; RGB = 0; o_video = 0; o_x = o_y = 0; o_frame_start = 0.
  - Syncs driven inactive (~SYNC_POL).
  - Shadow mode = 0, shadow colour = 0, so the first frame after reset is solid black.
- Reset release: counters start at (0,0); the first registered output shows pixel (0,0), with o_frame_start = 1, one clock after the first rising edge following release.
- Reset asserted mid-frame: all outputs reach reset values immediately; no partial-line recovery.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 timing constants;
  - pattern mode encodings MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_GRAD;
  - the colour-bar lookup constants.
- Sub-module vga_sync_counter contains the h/v counters, sync decode and active-area flag. It carries the same parameters and outputs unregistered h_cnt, v_cnt, hs, vs, active and frame_end.
- vga_pattern_gen contains the mode shadow registers, pattern generation and the output register stage.

Test Plan:
- Defaults, mode 0, rgb 0x00F -> hsync low for 96 clocks per 800-clock line; vsync low for exactly 2 lines (1600 clocks) per 525-line frame; blue = 0xF only where o_video = 1.
- Mode 1 -> o_x = 0..79 white 0xFFF; o_x = 80 yellow 0xFF0; o_x = 560..639 black; o_x = 640 RGB 0 with o_video = 0.
- Mode 2 -> (31,0) white/black per the XOR rule; (32,0) inverted; (32,32) equal to (0,0).
- Mode 3 -> (0,y) = 0x000; (64,y) = 0x111; (639,y) = 0x999.
- Switch i_mode 0 -> 1 at o_y = 200 -> rest of frame stays solid; bars begin at the next o_frame_start pulse, exactly one pulse per 420000 clocks.
- Assert reset at o_x = 300, o_y = 100 -> immediate syncs high, RGB 0, x/y 0; after release o_frame_start pulses at pixel (0,0); first frame black.
